raster_frame_reader: RTL and testbench
======================================

// Module: raster_frame_reader
// PURPOSE
//  Producer end of the row-major pixel stream consumed by the sliding-window line buffers.
//  Reads one frame from a synchronous frame-buffer RAM and emits it top-to-bottom, left-to-right.
//  Every beat carries x/y coordinates and frame markers; the output applies valid/ready backpressure.
//  Sits between frame-buffer memory and the windowing/filter pipeline.
// PARAMETERS
//  DATA_BITS     8   pixel width
//  COORD_BITS    11  width of x/y, r_row_length, r_num_rows
//  ADDR_BITS     20  frame-buffer word address width
//  READ_LATENCY  1   cycles from mem_rd_en to mem_rd_data valid (>=1, fixed)
//  FIFO_DEPTH    READ_LATENCY+2  internal return-buffer entries
// PORTS
//  clk           in   1           clock
//  reset         in   1           asynchronous, active-high reset
//  r_row_length  in   COORD_BITS  pixels per row; sampled on accepted start
//  r_num_rows    in   COORD_BITS  rows per frame; sampled on accepted start
//  r_base_addr   in   ADDR_BITS   address of pixel (0,0); sampled on accepted start
//  start         in   1           one-cycle request to read a frame
//  busy          out  1           high from accepted start until done
//  done          out  1           one-cycle pulse at frame completion
//  mem_rd_en     out  1           read strobe
//  mem_addr      out  ADDR_BITS   read address
//  mem_rd_data   in   DATA_BITS   read data, READ_LATENCY cycles after mem_rd_en
//  out_valid     out  1           beat available
//  out_ready     in   1           downstream accepts; transfer = out_valid & out_ready
//  out_data      out  DATA_BITS   pixel
//  out_x,out_y   out  COORD_BITS  pixel coordinates
//  out_sof       out  1           beat is (0,0)
//  out_eol       out  1           beat is x = r_row_length-1
//  out_eof       out  1           beat is the last pixel of the frame
// BEHAVIOUR
//  Reset: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_* markers/coords=0.
//   All counters, the FIFO and the read-latency tracker are cleared.
//   In-flight RAM returns are discarded. No stale beat may be emitted after reset.
//  FSM: IDLE -> (start) -> READ -> (last address issued) -> DRAIN -> (eof beat transferred) -> IDLE.
//   done is asserted for one cycle in the cycle after the eof transfer; busy falls with done.
//  start is honoured only in IDLE; start while busy is ignored.
//  Zero size: r_row_length==0 or r_num_rows==0 -> no reads, no beats; done pulses the cycle after start.
//  Issue rule: in READ, mem_rd_en=1 when (reads in flight + FIFO occupancy) < FIFO_DEPTH.
//   This credit scheme guarantees the FIFO never overflows and no return is lost.
//  Address generation: incremental, mem_addr = r_base_addr + y*r_row_length + x. No multiplier.
//   Address wraps modulo 2^ADDR_BITS.
//  Issue counters advance x then y; x wraps at r_row_length-1.
//   Coordinates/markers are computed at issue time and travel with the request through a READ_LATENCY-deep tag pipe.
//  Returns (data + tag) are written into the FIFO. out_* is the FIFO head; out_valid = !empty.
//  out_* are held stable while out_valid & !out_ready.
//  Latency: first beat valid READ_LATENCY+1 cycles after start, when out_ready is held high.
//   Sustained throughput is 1 beat/clk.
//  Simultaneous FIFO push and pop in one cycle are both performed; occupancy is unchanged.
//  1x1 frame: the single beat has sof=eol=eof=1.
//  Reset mid-frame: immediate return to IDLE; done is not pulsed.
// STRUCTURE
//  Shared package raster_pkg: typedef struct packed {data, x, y, sof, eol, eof} pixel_beat_t; enum {IDLE, READ, DRAIN}.
//  Sub-module beat_fifo: synchronous FIFO of pixel_beat_t, DEPTH parameter, push/pop/empty/full/count.
//   Asynchronous reset; simultaneous push/pop allowed.
//  Top level contains the FSM, issue counters, credit counter and tag pipe.
// TESTING
//  4x3 frame, base 0x100, out_ready=1:
//   -> 12 beats, data=mem[0x100..0x10B] in order; sof on beat 0; eol on x=3; eof on beat 11.
//   -> done one cycle after beat 11; first beat 2 cycles after start (READ_LATENCY=1).
//  Same frame with out_ready toggling 1,0,0,1 repeating:
//   -> identical beat sequence; outputs stable while stalled; FIFO count never exceeds FIFO_DEPTH.
//   -> mem_rd_en drops when credits are exhausted.
//  r_row_length=0, r_num_rows=5:
//   -> no mem_rd_en, no out_valid; done pulses the cycle after start.
//  1x1 frame:
//   -> one beat with sof=eol=eof=1, x=y=0; done follows.
//  Reset asserted mid-frame at beat 5 of a 4x3 frame with reads in flight:
//   -> out_valid=0 and busy=0 immediately; no beat emitted after release.
//   -> a new start reads the next frame cleanly from (0,0).
//  start pulsed while busy; READ_LATENCY=3 build:
//   -> second start ignored; beat count still 12; throughput 1/clk with out_ready=1.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types for the raster frame reader: FSM states, issue-time tag and FIFO beat.
package raster_pkg;

    localparam int unsigned PIX_DATA_BITS  = 8;
    localparam int unsigned PIX_COORD_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    typedef struct packed {
        logic [PIX_COORD_BITS-1:0] x;
        logic [PIX_COORD_BITS-1:0] y;
        logic                      sof;
        logic                      eol;
        logic                      eof;
    } pixel_tag_t;

    typedef struct packed {
        logic [PIX_DATA_BITS-1:0]  data;
        logic [PIX_COORD_BITS-1:0] x;
        logic [PIX_COORD_BITS-1:0] y;
        logic                      sof;
        logic                      eol;
        logic                      eof;
    } pixel_beat_t;

endpackage

// File: rtl/beat_fifo.sv
// Synchronous FIFO of pixel beats; simultaneous push and pop leave occupancy unchanged.
module beat_fifo
    import raster_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  pixel_beat_t      i_din,
    input  logic             i_pop,
    output pixel_beat_t      o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    pixel_beat_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push, w_do_pop;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/raster_frame_reader.sv
// Reads one row-major frame from a fixed-latency RAM and streams it with coordinates,
// frame markers and valid/ready backpressure.
module raster_frame_reader
    import raster_pkg::*;
#(
    parameter int unsigned DATA_BITS    = PIX_DATA_BITS,
    parameter int unsigned COORD_BITS   = PIX_COORD_BITS,
    parameter int unsigned ADDR_BITS    = 20,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_BITS-1:0] r_row_length,
    input  logic [COORD_BITS-1:0] r_num_rows,
    input  logic [ADDR_BITS-1:0]  r_base_addr,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_BITS-1:0]  mem_addr,
    input  logic [DATA_BITS-1:0]  mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data,
    output logic [COORD_BITS-1:0] out_x,
    output logic [COORD_BITS-1:0] out_y,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic       vld;
        pixel_tag_t tag;
    } tag_slot_t;

    rd_state_t                    r_state, w_state_nxt;
    logic [COORD_BITS-1:0]        r_len, r_rows, r_x, r_y;
    logic [COORD_BITS-1:0]        w_len, w_rows, w_cur_x, w_cur_y;
    logic [ADDR_BITS-1:0]         r_addr, w_cur_addr;
    logic [CNT_W-1:0]             r_inflight, w_fifo_count, w_used;
    tag_slot_t [READ_LATENCY-1:0] r_pipe;
    tag_slot_t                    w_slot_in, w_slot_ret;
    pixel_beat_t                  w_push_beat, w_head, w_out;
    logic                         w_idle, w_zero, w_last_x, w_last, w_credit, w_issue, w_pop;
    logic                         w_fifo_empty, w_fifo_full, r_done, w_done_nxt;

    // The first read issues in the start cycle itself, straight from the input geometry.
    assign w_idle     = (r_state == IDLE);
    assign w_len      = w_idle ? r_row_length : r_len;
    assign w_rows     = w_idle ? r_num_rows   : r_rows;
    assign w_cur_x    = w_idle ? '0 : r_x;
    assign w_cur_y    = w_idle ? '0 : r_y;
    assign w_cur_addr = w_idle ? r_base_addr : r_addr;
    assign w_zero     = (w_len == '0) || (w_rows == '0);
    assign w_last_x   = (w_cur_x == w_len - COORD_BITS'(1));
    assign w_last     = w_last_x && (w_cur_y == w_rows - COORD_BITS'(1));
    assign w_used     = r_inflight + w_fifo_count;
    assign w_credit   = !w_fifo_full && (w_used < CNT_W'(FIFO_DEPTH));
    assign w_pop      = !w_fifo_empty && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = w_last ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pop && w_head.eof) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_rows     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_inflight <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_idle && start) begin
                r_len  <= r_row_length;
                r_rows <= r_num_rows;
            end
            if (w_issue) begin
                r_x    <= w_last_x ? '0 : w_cur_x + COORD_BITS'(1);
                r_y    <= w_last_x ? w_cur_y + COORD_BITS'(1) : w_cur_y;
                r_addr <= w_cur_addr + ADDR_BITS'(1);
            end
            case ({w_issue, w_slot_ret.vld})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign w_slot_in = '{vld: w_issue,
                         tag: '{x:   w_cur_x,
                                y:   w_cur_y,
                                sof: (w_cur_x == '0) && (w_cur_y == '0),
                                eol: w_last_x,
                                eof: w_last}};

    if (READ_LATENCY == 1) begin : g_pipe_1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= w_slot_in;
            end
        end
    end else begin : g_pipe_n
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[READ_LATENCY-2:0], w_slot_in};
            end
        end
    end

    assign w_slot_ret  = r_pipe[READ_LATENCY-1];
    assign w_push_beat = '{data: mem_rd_data,
                           x:    w_slot_ret.tag.x,
                           y:    w_slot_ret.tag.y,
                           sof:  w_slot_ret.tag.sof,
                           eol:  w_slot_ret.tag.eol,
                           eof:  w_slot_ret.tag.eof};

    beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_slot_ret.vld),
        .i_din   (w_push_beat),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    assign w_out     = w_fifo_empty ? '0 : w_head;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_out.data;
    assign out_x     = w_out.x;
    assign out_y     = w_out.y;
    assign out_sof   = w_out.sof;
    assign out_eol   = w_out.eol;
    assign out_eof   = w_out.eof;

    assign busy      = !w_idle;
    assign done      = r_done;
    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? w_cur_addr : r_addr;

endmodule

// File: tb/tb_raster_frame_reader.sv
// Directed bench for raster_frame_reader: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
module tb_raster_frame_reader;

    logic        clk = 1'b0;
    logic        reset, start, out_ready, sel;
    logic [10:0] len, rows;
    logic [19:0] base;
    logic        start_a, start_b;

    logic        busy_a, done_a, rd_a, valid_a, sof_a, eol_a, eof_a;
    logic [19:0] addr_a;
    logic [7:0]  md_a, data_a;
    logic [10:0] x_a, y_a;
    logic        busy_b, done_b, rd_b, valid_b, sof_b, eol_b, eof_b;
    logic [19:0] addr_b;
    logic [7:0]  md_b, data_b;
    logic [10:0] x_b, y_b;
    logic [7:0]  mq_b [3];

    logic        o_busy, o_done, o_rd, o_valid, o_sof, o_eol, o_eof;
    logic [19:0] o_addr;
    logic [7:0]  o_data;
    logic [10:0] o_x, o_y;
    logic [31:0] obs_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    raster_frame_reader #(.READ_LATENCY(1)) u_a (
        .clk(clk), .reset(reset), .r_row_length(len), .r_num_rows(rows), .r_base_addr(base),
        .start(start_a), .busy(busy_a), .done(done_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
        .mem_rd_data(md_a), .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
        .out_x(x_a), .out_y(y_a), .out_sof(sof_a), .out_eol(eol_a), .out_eof(eof_a)
    );

    raster_frame_reader #(.READ_LATENCY(3)) u_b (
        .clk(clk), .reset(reset), .r_row_length(len), .r_num_rows(rows), .r_base_addr(base),
        .start(start_b), .busy(busy_b), .done(done_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
        .mem_rd_data(md_b), .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
        .out_x(x_b), .out_y(y_b), .out_sof(sof_b), .out_eol(eol_b), .out_eof(eof_b)
    );

    function automatic logic [7:0] pix(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'hA5;
    endfunction

    // Frame-buffer models: unread cycles return a poison value.
    always @(posedge clk) begin
        md_a     <= rd_a ? pix(addr_a) : 8'hEE;
        mq_b[0]  <= rd_b ? pix(addr_b) : 8'hEE;
        mq_b[1]  <= mq_b[0];
        mq_b[2]  <= mq_b[1];
    end
    assign md_b = mq_b[2];

    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_rd    = sel ? rd_b    : rd_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_data  = sel ? data_b  : data_a;
    assign o_x     = sel ? x_b     : x_a;
    assign o_y     = sel ? y_b     : y_a;
    assign o_sof   = sel ? sof_b   : sof_a;
    assign o_eol   = sel ? eol_b   : eol_a;
    assign o_eof   = sel ? eof_b   : eof_a;
    assign obs_cnt = sel ? 32'(u_b.w_fifo_count) : 32'(u_a.w_fifo_count);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one frame; stall=1 toggles out_ready 1,0,0,1; restart_at pulses start again mid-frame.
    task automatic run_frame(input logic s, input int l, input int r, input logic [19:0] b,
                             input int stall, input int restart_at);
        int   total, lat, depth, k, issued, done_c, eof_c, ndone, gap;
        bit   done_seen;
        logic [2:0] ef;
        sel = s; lat = s ? 3 : 1; depth = lat + 2;
        total = l * r; k = 0; issued = 0; done_c = -1; eof_c = -1; ndone = 0; gap = 0;
        done_seen = 0;
        len = 11'(l); rows = 11'(r); base = b;
        for (int c = 0; c < 300 && !(done_seen && c > done_c + 2); c++) begin
            start     = (c == 0) || (c == restart_at);
            out_ready = (stall == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            #1;
            if (o_rd) begin
                chk("rd_addr", 32'(o_addr), 32'(20'(32'(b) + issued)));
                issued++;
            end else if (o_busy && issued < total) begin
                gap++;
            end
            chk("fifo_bound", 32'(obs_cnt <= 32'(depth)), 32'd1);
            if (k >= total) begin
                chk("no_extra_beat", 32'(o_valid), 32'd0);
            end else if (o_valid) begin
                ef = {k == 0, (k % l) == l - 1, k == total - 1};
                chk("beat_data", 32'(o_data), 32'(pix(20'(32'(b) + k))));
                chk("beat_xy", 32'({o_x, o_y}), 32'({11'(k % l), 11'(k / l)}));
                chk("beat_flags", 32'({o_sof, o_eol, o_eof}), 32'(ef));
                if (out_ready) begin
                    if (stall == 0) chk("beat_cycle", c, lat + 1 + k);
                    if (k == total - 1) eof_c = c;
                    k++;
                end
            end
            if (o_done) begin
                ndone++;
                if (!done_seen) begin
                    done_seen = 1;
                    done_c    = c;
                    chk("busy_at_done", 32'(o_busy), 32'd0);
                end
            end
            step();
        end
        start = 1'b0;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("beat_count", k, total);
        chk("read_count", issued, total);
        chk("done_pulses", ndone, 1);
        if (stall == 0) chk("done_cycle", done_c, (total == 0) ? 1 : lat + 1 + total);
        else            chk("done_after_eof", done_c, eof_c + 1);
        if (stall != 0) chk("credit_stall", 32'(gap > 0), 32'd1);
    endtask

    initial begin
        int k;
        bit hit;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; sel = 1'b0;
        len = '0; rows = '0; base = '0;
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_busy",  32'(o_busy),  32'd0);
            chk("rst_done",  32'(o_done),  32'd0);
            chk("rst_rd_en", 32'(o_rd),    32'd0);
            chk("rst_addr",  32'(o_addr),  32'd0);
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_beat",  32'({o_data, o_sof, o_eol, o_eof}), 32'd0);
            chk("rst_xy",    32'({o_x, o_y}), 32'd0);
        end
        step();
        reset = 1'b0;

        run_frame(1'b0, 4, 3, 20'h00100, 0, -1);
        run_frame(1'b0, 4, 3, 20'h00100, 1, -1);
        run_frame(1'b0, 0, 5, 20'h00100, 0, -1);
        run_frame(1'b0, 1, 1, 20'h00040, 0, -1);

        // Reset while beat 5 is presented and later reads are still in flight.
        sel = 1'b0; len = 11'd4; rows = 11'd3; base = 20'h00100; k = 0; hit = 0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0); out_ready = 1'b1;
            #1;
            if (o_valid && k == 5) begin
                hit = 1;
                break;
            end
            if (o_valid) k++;
            step();
        end
        chk("midrst_reached", 32'(hit), 32'd1);
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_busy",  32'(o_busy),  32'd0);
        chk("midrst_done",  32'(o_done),  32'd0);
        chk("midrst_rd_en", 32'(o_rd),    32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("post_rst_valid", 32'(o_valid), 32'd0);
            chk("post_rst_done",  32'(o_done),  32'd0);
            chk("post_rst_rd_en", 32'(o_rd),    32'd0);
            step();
        end
        run_frame(1'b0, 4, 3, 20'h00200, 0, -1);

        run_frame(1'b0, 2, 2, 20'hFFFFE, 0, -1);
        run_frame(1'b1, 4, 3, 20'h00100, 0, 3);
        run_frame(1'b1, 4, 3, 20'h00300, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1, "watchdog");
    end

endmodule
